// File: rtl/bf_pkg.sv
// Shared constants and state encoding for the Bellman-Ford engine and its
// Output Memory result streamer.
package bf_pkg;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 16;
  localparam int CNT_W  = ADDR_W + 1;

  localparam logic [DATA_W-1:0] INF_CODE  = 16'hFFFF;
  localparam logic [CNT_W-1:0]  MAX_COUNT = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    DONE
  } state_t;

  // Memory holds at most 2^ADDR_W entries, so larger requests are capped.
  function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] c);
    return (c > MAX_COUNT) ? MAX_COUNT : c;
  endfunction

endpackage

// File: rtl/bf_word_decode.sv
// Maps a raw Output Memory distance word onto the streamed data/inf pair.
module bf_word_decode
  import bf_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  output logic [DATA_W-1:0] data,
  output logic              inf
);

  assign inf  = (word == INF_CODE);
  assign data = inf ? '0 : word;

endmodule

// File: rtl/bf_result_streamer.sv
// Walks the Output Memory after the engine finishes and streams one distance
// per valid/ready beat, or a single marker beat when a negative cycle exists.
module bf_result_streamer
  import bf_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              neg_cycle,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] omar,
  input  logic [DATA_W-1:0] omdr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_inf,
  output logic              out_neg,
  output logic              out_last,
  output logic              done
);

  state_t            state;
  state_t            next_state;
  logic              armed;
  logic [ADDR_W:0]   cnt_r;
  logic [ADDR_W:0]   cnt_m1;
  logic [ADDR_W-1:0] last_idx;
  logic [ADDR_W-1:0] idx_next;
  logic              handshake;
  logic [DATA_W-1:0] dec_data;
  logic              dec_inf;

  assign cnt_m1    = cnt_r - {{ADDR_W{1'b0}}, 1'b1};
  assign last_idx  = cnt_m1[ADDR_W-1:0];
  assign idx_next  = out_index + ADDR_W'(1);
  assign handshake = out_valid && out_ready;

  bf_word_decode u_decode (
    .word (omdr),
    .data (dec_data),
    .inf  (dec_inf)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // The read address runs one entry ahead of the beat on display so the next
  // word is already on omdr when the sink accepts; it stops at the last entry.
  always_comb begin
    next_state = state;
    omar       = '0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start && armed) begin
          if (neg_cycle) begin
            next_state = SEND;
          end else if (count == '0) begin
            next_state = DONE;
          end else begin
            next_state = LOAD;
          end
        end
      end
      LOAD: begin
        next_state = SEND;
      end
      SEND: begin
        if (!out_neg) begin
          omar = out_last ? out_index : idx_next;
        end
        if (handshake && out_last) begin
          next_state = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (!start) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // armed blocks a start that is still held high from the previous stream.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      armed     <= 1'b1;
      cnt_r     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_inf   <= 1'b0;
      out_neg   <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!start) begin
            armed <= 1'b1;
          end else if (armed) begin
            out_index <= '0;
            out_data  <= '0;
            out_inf   <= 1'b0;
            if (neg_cycle) begin
              out_valid <= 1'b1;
              out_neg   <= 1'b1;
              out_last  <= 1'b1;
            end else begin
              out_neg  <= 1'b0;
              out_last <= 1'b0;
              cnt_r    <= clamp_count(count);
            end
          end
        end
        LOAD: begin
          out_valid <= 1'b1;
          out_data  <= dec_data;
          out_inf   <= dec_inf;
          out_index <= '0;
          out_last  <= (last_idx == '0);
        end
        SEND: begin
          if (handshake) begin
            if (out_last) begin
              out_valid <= 1'b0;
            end else begin
              out_index <= idx_next;
              out_data  <= dec_data;
              out_inf   <= dec_inf;
              out_last  <= (idx_next == last_idx);
            end
          end
        end
        DONE: begin
          armed <= !start;
        end
        default: begin
          armed <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bf_result_streamer.sv
// Self-checking bench for bf_result_streamer: table-driven beat vectors plus
// hand-written sequences for stalls, negative cycles, empty streams and reset.
module tb_bf_result_streamer;

  logic        clock;
  logic        reset;
  logic        start;
  logic        neg_cycle;
  logic [13:0] count;
  logic [12:0] omar;
  logic [15:0] omdr;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [12:0] out_index;
  logic        out_inf;
  logic        out_neg;
  logic        out_last;
  logic        done;

  logic [15:0] mem [0:8191];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] word;
    logic [12:0] index;
    logic [15:0] data;
    logic        inf;
    logic        last;
  } vec_t;

  vec_t        vecs [4];
  logic [31:0] exp_q [$];
  logic [15:0] ready_pat = 16'b1001_0110_1100_1001;

  assign omdr = mem[omar];

  bf_result_streamer dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .neg_cycle (neg_cycle),
    .count     (count),
    .omar      (omar),
    .omdr      (omdr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_inf   (out_inf),
    .out_neg   (out_neg),
    .out_last  (out_last),
    .done      (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] pack_beat(input logic neg, input logic last,
                                            input logic inf, input logic [12:0] index,
                                            input logic [15:0] data);
    return {neg, last, inf, index, data};
  endfunction

  function automatic logic [31:0] dut_beat();
    return {out_neg, out_last, out_inf, out_index, out_data};
  endfunction

  // Reference mapping of a memory word onto the expected beat.
  task automatic push_expected(input int index, input logic [15:0] word, input logic last);
    logic inf;
    inf = (word == 16'hFFFF);
    exp_q.push_back(pack_beat(1'b0, last, inf, 13'(index), inf ? 16'h0 : word));
  endtask

  task automatic apply_stimulus(input logic [13:0] cnt, input logic neg);
    count     = cnt;
    neg_cycle = neg;
    start     = 1'b1;
  endtask

  // Consumes every beat queued in exp_q; start is dropped after one cycle.
  task automatic consume_stream(input string tag, input bit rand_ready, input int exp_lat,
                                input bit scramble, input int exp_omar_max);
    int          n;
    int          k;
    int          cyc;
    int          omar_max;
    bit          stalled;
    logic [32:0] held;
    logic [32:0] cur;
    n        = exp_q.size();
    k        = 0;
    cyc      = 0;
    omar_max = 0;
    stalled  = 1'b0;
    held     = '0;
    while (k < n && cyc < n * 4 + 20) begin
      @(negedge clock);
      cyc++;
      start = 1'b0;
      if (scramble && cyc == 1) begin
        count     = 14'd1;
        neg_cycle = 1'b1;
      end
      out_ready = rand_ready ? ready_pat[cyc % 16] : 1'b1;
      cur = {out_valid, dut_beat()};
      if (stalled) check_output({tag, "_stall_hold"}, 64'(cur), 64'(held));
      stalled = 1'b0;
      if (out_valid) begin
        if (int'(omar) > omar_max) omar_max = int'(omar);
        if (k == 0 && cyc <= exp_lat) check_output({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
        if (out_neg) check_output({tag, "_neg_omar"}, 64'(omar), 64'd0);
        if (out_ready) begin
          check_output({tag, "_beat"}, 64'(dut_beat()), 64'(exp_q[k]));
          k++;
        end else begin
          stalled = 1'b1;
          held    = cur;
        end
      end
    end
    if (k < n) check_output({tag, "_timeout"}, 64'(k), 64'(n));
    if (exp_omar_max >= 0) check_output({tag, "_omar_max"}, 64'(omar_max), 64'(exp_omar_max));
    @(negedge clock);
    check_output({tag, "_done"}, 64'({done, out_valid}), 64'(2'b10));
    out_ready = 1'b1;
    neg_cycle = 1'b0;
    count     = 14'd0;
    exp_q.delete();
    repeat (2) @(negedge clock);
  endtask

  initial begin
    int valid_seen;
    int done_drop;
    int guard;

    vecs[0] = '{word: 16'd5,     index: 13'd0, data: 16'd5,  inf: 1'b0, last: 1'b0};
    vecs[1] = '{word: 16'hFFFF,  index: 13'd1, data: 16'd0,  inf: 1'b1, last: 1'b0};
    vecs[2] = '{word: 16'd0,     index: 13'd2, data: 16'd0,  inf: 1'b0, last: 1'b0};
    vecs[3] = '{word: 16'd12,    index: 13'd3, data: 16'd12, inf: 1'b0, last: 1'b1};

    for (int i = 0; i < 8192; i++) mem[i] = 16'h0;
    reset     = 1'b1;
    start     = 1'b0;
    neg_cycle = 1'b0;
    count     = 14'd0;
    out_ready = 1'b1;
    repeat (2) @(negedge clock);
    check_output("reset_state",
                 64'({out_valid, out_neg, out_last, out_inf, out_index, out_data, done, omar}),
                 64'd0);
    reset = 1'b0;
    @(negedge clock);

    $display("[TB] basic stream, ready held high");
    for (int i = 0; i < 4; i++) begin
      mem[i] = vecs[i].word;
      exp_q.push_back(pack_beat(1'b0, vecs[i].last, vecs[i].inf, vecs[i].index, vecs[i].data));
    end
    apply_stimulus(14'd4, 1'b0);
    consume_stream("basic", 1'b0, 2, 1'b0, -1);

    $display("[TB] same stream with stalling sink and late input changes");
    for (int i = 0; i < 4; i++)
      exp_q.push_back(pack_beat(1'b0, vecs[i].last, vecs[i].inf, vecs[i].index, vecs[i].data));
    apply_stimulus(14'd4, 1'b0);
    consume_stream("stall", 1'b1, 2, 1'b1, -1);

    $display("[TB] negative-cycle marker");
    exp_q.push_back(pack_beat(1'b1, 1'b1, 1'b0, 13'd0, 16'd0));
    apply_stimulus(14'd4, 1'b1);
    consume_stream("neg", 1'b0, 1, 1'b0, -1);

    $display("[TB] empty stream and held start");
    apply_stimulus(14'd0, 1'b0);
    @(negedge clock);
    check_output("zero_done", 64'({done, out_valid}), 64'(2'b10));
    valid_seen = 0;
    done_drop  = 0;
    repeat (20) begin
      @(negedge clock);
      if (out_valid) valid_seen++;
      if (!done) done_drop++;
    end
    check_output("zero_no_valid", 64'(valid_seen), 64'd0);
    check_output("held_start_no_restart", 64'(done_drop), 64'd0);
    start = 1'b0;
    repeat (2) @(negedge clock);
    check_output("zero_return_idle", 64'(done), 64'd0);
    for (int i = 0; i < 4; i++)
      exp_q.push_back(pack_beat(1'b0, vecs[i].last, vecs[i].inf, vecs[i].index, vecs[i].data));
    apply_stimulus(14'd4, 1'b0);
    consume_stream("restart", 1'b0, 2, 1'b0, -1);

    $display("[TB] reset during beat 2 of an 8-entry stream");
    for (int i = 0; i < 8; i++) mem[i] = 16'(i * 7 + 1);
    out_ready = 1'b1;
    apply_stimulus(14'd8, 1'b0);
    guard = 0;
    do begin
      @(negedge clock);
      start = 1'b0;
      guard++;
    end while (!(out_valid && out_index == 13'd2) && guard < 20);
    check_output("reach_beat2", 64'({out_valid, out_index}), 64'({1'b1, 13'd2}));
    #2 reset = 1'b1;
    #1 check_output("async_reset",
                    64'({out_valid, out_neg, out_last, out_inf, out_index, out_data, done, omar}),
                    64'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 8; i++) push_expected(i, mem[i], i == 7);
    apply_stimulus(14'd8, 1'b0);
    consume_stream("post_reset", 1'b0, 2, 1'b0, -1);

    $display("[TB] full memory stream");
    for (int i = 0; i < 8192; i++) mem[i] = 16'(i);
    for (int i = 0; i < 8192; i++) push_expected(i, mem[i], i == 8191);
    apply_stimulus(14'd8192, 1'b0);
    consume_stream("full", 1'b0, 2, 1'b0, 8191);

    $display("[TB] oversized count is capped at memory size");
    for (int i = 0; i < 8192; i++) push_expected(i, mem[i], i == 8191);
    apply_stimulus(14'd9000, 1'b0);
    consume_stream("clamp", 1'b0, 2, 1'b0, 8191);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bf_result_streamer.md
Name: bf_result_streamer

Overview:
Reads back the Output Memory after the bellmanford engine raises Finish. It walks the distance entries and streams them out over a valid/ready interface, one distance per beat. It is the reader for the engine's OMWAR/OMWDR/OMWE write port. It connects to the Output Memory read port (OMAR/OMDR), so testbenches and SoC glue no longer dump memory hierarchically. When NegCycle is set it emits a single negative-cycle marker beat instead of distances.

Parameters:
ADDR_W, 13, Output Memory address width
DATA_W, 16, distance word width
INF_CODE, 16'hFFFF, encoding for an unreachable vertex

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  level; connect to engine Finish
neg_cycle  input  1  connect to engine NegCycle; sampled with start
count  input  ADDR_W+1  number of entries to stream; sampled with start
omar  output  ADDR_W  Output Memory read address
omdr  input  DATA_W  Output Memory read data (combinational read of omar)
out_valid  output  1  beat available
out_ready  input  1  sink accepts beat
out_data  output  DATA_W  distance (0 when out_inf or out_neg)
out_index  output  ADDR_W  vertex index of current beat
out_inf  output  1  entry equals INF_CODE
out_neg  output  1  negative-cycle marker beat
out_last  output  1  final beat of stream
done  output  1  stream complete

Behaviour:
- Reset (async, any state): state=IDLE; out_valid, out_data, out_index, out_inf, out_neg, out_last, done and omar all 0.
- States: IDLE, LOAD, SEND, DONE.
- IDLE → transition on start==1 with armed==1:
  - neg_cycle==1 → SEND with a single marker beat: out_neg=1, out_last=1, out_data=0, out_index=0.
  - count==0 → DONE directly; no beats are emitted.
  - else latch count into cnt_r, then go to LOAD.
- LOAD: omar=0. Register omdr into the output register (index 0); set out_valid. Next state is SEND.
- SEND: out_valid=1.
  - All out_* signals hold stable while out_valid && !out_ready.
  - omar = out_index+1, driven combinationally so the next word is ready.
  - On handshake with out_index != cnt_r-1: load omdr, increment out_index, and update out_inf and out_last. This gives 1 beat per cycle at sustained ready.
  - On handshake of the last beat: clear out_valid and go to DONE.
- Word mapping: out_inf = (word==INF_CODE); out_data = out_inf ? 0 : word; out_last = (out_index == cnt_r-1).
- DONE: done=1. Clears `armed`; return to IDLE only after start==0, which sets armed=1. A start held high never retriggers a stream.
- Latency: start high in IDLE → first out_valid 2 cycles later (IDLE→LOAD→valid). For a neg_cycle stream it is 1 cycle.
- count > 2^ADDR_W is clamped to 2^ADDR_W. The index never wraps past 2^ADDR_W-1.
- neg_cycle and count changing after start are ignored until the next IDLE.
- A reset mid-stream aborts the stream; there is no partial completion flag.

Decomposition:
- Shared package bf_pkg: ADDR_W, DATA_W, INF_CODE, and the state enum (IDLE/LOAD/SEND/DONE). The engine reuses ADDR_W, DATA_W and INF_CODE.
- Optional sub-module bf_word_decode: combinational INF/data mapping. Everything else stays in one module.

Test Plan:
- Output Memory preloaded {5, FFFF, 0, 12}, count=4, ready tied 1, start pulse high:
  - Beats (index,data,inf) = (0,5,0), (1,0,1), (2,0,0), (3,12,0) on consecutive cycles.
  - out_last only on index 3; done=1 the cycle after.
- Same data with out_ready toggled 1-0-0-1 randomly → identical beat sequence; outputs stable during every stall.
- neg_cycle=1 with start → exactly one beat: out_neg=1, out_last=1, out_data=0. Then done=1, and no omar-driven reads are consumed.
- count=0 → done within 1 cycle with no out_valid. Holding start=1 for 20 cycles produces no restart; dropping start then raising it starts a new stream.
- Assert reset for 1 cycle during beat 2 of a count=8 stream → all outputs 0 immediately (async). After start is toggled, the stream restarts at index 0.
- count=8192, memory[i]=i → 8192 beats with out_index 0..8191 and out_last only at 8191; omar never exceeds 8191.
